// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared timing constants for the 640x480@60 Hz VGA raster generator.
//   - Visible area, porch and sync widths for both axes
//   - Derived line / frame totals
//   - Raster counter width
// Optional build macro used by vga_timing_gen: VGA_TIMING_FRAME_CNT_EN
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int VGA_WIDTH   = 640;
  localparam int VGA_H_FRONT = 16;
  localparam int VGA_H_SYNC  = 96;
  localparam int VGA_H_BACK  = 48;

  localparam int VGA_HEIGHT  = 480;
  localparam int VGA_V_FRONT = 10;
  localparam int VGA_V_SYNC  = 2;
  localparam int VGA_V_BACK  = 33;

  localparam int VGA_H_TOTAL = VGA_WIDTH + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL = VGA_HEIGHT + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
// Modulo-MAX up counter for one raster axis.
// Ports:
//   i_clk    : clock, rising edge
//   i_rst    : asynchronous active-high reset, clears the count
//   i_en     : advance the count on this edge
//   o_count  : current count, 0..MAX-1
//   o_wrap   : high when enabled and at MAX-1, i.e. this edge wraps to 0
module vga_axis_counter #(
  parameter int MAX = 800,
  parameter int W   = 10
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_wrap
);

  localparam logic [W-1:0] L_LAST = W'(MAX - 1);

  logic [W-1:0] r_count;

  assign o_wrap  = i_en && (r_count == L_LAST);
  assign o_count = r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_wrap ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// VGA raster timing generator (default 640x480@60 Hz from a 25 MHz pixel clock).
// Ports:
//   clk25      : pixel clock, rising edge
//   reset      : asynchronous active-high reset
//   screenEnd  : one-cycle pulse on the first output cycle of line HEIGHT
//   active     : visible region being drawn
//   hSync      : horizontal sync, active low
//   vSync      : vertical sync, active low
//   x, y       : current pixel column / row, 0 outside the visible area
//   frameCount : frames completed, only with VGA_TIMING_FRAME_CNT_EN defined
// All outputs are registered from the pre-increment counter values, so they
// lag the internal (h,v) counters by exactly one clock.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int WIDTH   = VGA_WIDTH,
  parameter int HEIGHT  = VGA_HEIGHT,
  parameter int H_FRONT = VGA_H_FRONT,
  parameter int H_SYNC  = VGA_H_SYNC,
  parameter int H_BACK  = VGA_H_BACK,
  parameter int V_FRONT = VGA_V_FRONT,
  parameter int V_SYNC  = VGA_V_SYNC,
  parameter int V_BACK  = VGA_V_BACK
) (
  input  logic        clk25,
  input  logic        reset,
  output logic        screenEnd,
  output logic        active,
  output logic        hSync,
  output logic        vSync,
  output logic [9:0]  x,
  output logic [8:0]  y
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0] frameCount
`endif
);

  localparam int H_TOTAL = WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = HEIGHT + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(WIDTH + H_FRONT);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(WIDTH + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(HEIGHT);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(HEIGHT + V_FRONT);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(HEIGHT + V_FRONT + V_SYNC);

  logic [CNT_W-1:0] w_h_p0;
  logic [CNT_W-1:0] w_v_p0;
  logic             w_h_wrap;
  // The frame wrap is implied by the counters themselves; decode does not need it.
  logic             w_v_wrap_unused;

  vga_axis_counter #(.MAX(H_TOTAL), .W(CNT_W)) u_h_cnt (
    .i_clk   (clk25),
    .i_rst   (reset),
    .i_en    (1'b1),
    .o_count (w_h_p0),
    .o_wrap  (w_h_wrap)
  );

  vga_axis_counter #(.MAX(V_TOTAL), .W(CNT_W)) u_v_cnt (
    .i_clk   (clk25),
    .i_rst   (reset),
    .i_en    (w_h_wrap),
    .o_count (w_v_p0),
    .o_wrap  (w_v_wrap_unused)
  );

  // ---- stage p0: decode of the current counter pair ----
  logic       w_h_vis_p0;
  logic       w_v_vis_p0;
  logic       w_active_p0;
  logic       w_hsync_p0;
  logic       w_vsync_p0;
  logic       w_se_p0;
  logic [9:0] w_x_p0;
  logic [8:0] w_y_p0;

  assign w_h_vis_p0  = (w_h_p0 < H_ACT_END);
  assign w_v_vis_p0  = (w_v_p0 < V_ACT_END);
  assign w_active_p0 = w_h_vis_p0 && w_v_vis_p0;
  assign w_hsync_p0  = !((w_h_p0 >= H_SYNC_BEG) && (w_h_p0 < H_SYNC_END));
  assign w_vsync_p0  = !((w_v_p0 >= V_SYNC_BEG) && (w_v_p0 < V_SYNC_END));
  assign w_se_p0     = (w_h_p0 == '0) && (w_v_p0 == V_ACT_END);
  assign w_x_p0      = w_h_vis_p0 ? w_h_p0 : '0;
  assign w_y_p0      = w_v_vis_p0 ? w_v_p0[8:0] : '0;

  // ---- stage p1: registered outputs ----
  logic       r_active_p1;
  logic       r_hsync_p1;
  logic       r_vsync_p1;
  logic       r_se_p1;
  logic [9:0] r_x_p1;
  logic [8:0] r_y_p1;

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      r_active_p1 <= 1'b0;
      r_hsync_p1  <= 1'b1;
      r_vsync_p1  <= 1'b1;
      r_se_p1     <= 1'b0;
      r_x_p1      <= '0;
      r_y_p1      <= '0;
    end else begin
      r_active_p1 <= w_active_p0;
      r_hsync_p1  <= w_hsync_p0;
      r_vsync_p1  <= w_vsync_p0;
      r_se_p1     <= w_se_p0;
      r_x_p1      <= w_x_p0;
      r_y_p1      <= w_y_p0;
    end
  end

  assign screenEnd = r_se_p1;
  assign active    = r_active_p1;
  assign hSync     = r_hsync_p1;
  assign vSync     = r_vsync_p1;
  assign x         = r_x_p1;
  assign y         = r_y_p1;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Counts on the same edge that registers screenEnd high.
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      r_frame_cnt <= '0;
    end else if (w_se_p0) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frameCount = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Bench for vga_timing_gen: one instance with the standard 640x480 geometry and
// one with a reduced geometry so whole frames fit in a short run. Every clock
// both instances are compared with a reference model that derives the expected
// outputs from the number of edges since reset release.
// Optional build macro: VGA_TIMING_FRAME_CNT_EN (also checks frameCount).
module tb_vga_timing_gen;

  localparam int S_W  = 20, S_H  = 12;
  localparam int S_HF = 2,  S_HS = 3, S_HB = 3;
  localparam int S_VF = 2,  S_VS = 2, S_VB = 3;
  localparam int S_HT = S_W + S_HF + S_HS + S_HB;   // 28
  localparam int S_VT = S_H + S_VF + S_VS + S_VB;   // 19
  localparam int S_FRAME = S_HT * S_VT;             // 532

  logic clk25 = 1'b0;
  logic reset = 1'b1;

  logic       se_b, act_b, hs_b, vs_b;
  logic [9:0] x_b;
  logic [8:0] y_b;
  logic       se_s, act_s, hs_s, vs_s;
  logic [9:0] x_s;
  logic [8:0] y_s;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fc_b, fc_s;
`endif

  vga_timing_gen u_dut_big (
    .clk25     (clk25),
    .reset     (reset),
    .screenEnd (se_b),
    .active    (act_b),
    .hSync     (hs_b),
    .vSync     (vs_b),
    .x         (x_b),
    .y         (y_b)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    .frameCount(fc_b)
`endif
  );

  vga_timing_gen #(
    .WIDTH(S_W), .HEIGHT(S_H), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
  ) u_dut_small (
    .clk25     (clk25),
    .reset     (reset),
    .screenEnd (se_s),
    .active    (act_s),
    .hSync     (hs_s),
    .vSync     (vs_s),
    .x         (x_s),
    .y         (y_s)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    .frameCount(fc_s)
`endif
  );

  always #20 clk25 = ~clk25;

  int n_tests = 0;
  int n_fail  = 0;
  int k       = 0;      // edges since reset release
  int se_cnt_s = 0;     // screenEnd pulses seen on the small instance
  int vs_run_s = 0;     // current vSync-low run length, small instance
  int vs_last_run_s = 0;

  localparam logic [22:0] RST_V = {1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 9'd0};

  // Packed as {screenEnd, active, hSync, vSync, x, y}.
  function automatic logic [22:0] model(input int kk, input int w, input int hh,
                                        input int hf, input int hsw, input int hb,
                                        input int vf, input int vsw, input int vb);
    int ht, vt, p, h, v;
    logic se, act, hs, vs;
    logic [9:0] xx;
    logic [8:0] yy;
    if (kk <= 0) return RST_V;
    ht  = w + hf + hsw + hb;
    vt  = hh + vf + vsw + vb;
    p   = (kk - 1) % (ht * vt);
    h   = p % ht;
    v   = p / ht;
    act = (h < w) && (v < hh);
    hs  = !((h >= w + hf) && (h < w + hf + hsw));
    vs  = !((v >= hh + vf) && (v < hh + vf + vsw));
    se  = (h == 0) && (v == hh);
    xx  = (h < w) ? 10'(h) : 10'd0;
    yy  = (v < hh) ? 9'(v) : 9'd0;
    return {se, act, hs, vs, xx, yy};
  endfunction

  function automatic logic [22:0] got_big();
    return {se_b, act_b, hs_b, vs_b, x_b, y_b};
  endfunction

  function automatic logic [22:0] got_small();
    return {se_s, act_s, hs_s, vs_s, x_s, y_s};
  endfunction

  task automatic check(input string name, input logic [22:0] got, input logic [22:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d got=%h expected=%h", name, k, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_big"}, got_big(), RST_V);
    check({tag, "_small"}, got_small(), RST_V);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check_int({tag, "_fc_big"}, int'(fc_b), 0);
    check_int({tag, "_fc_small"}, int'(fc_s), 0);
`endif
  endtask

  // One clock: advance, then compare both instances against the model.
  task automatic step();
    @(posedge clk25);
    #1;
    k++;
    check("model_big", got_big(), model(k, 640, 480, 16, 96, 48, 10, 2, 33));
    check("model_small", got_small(), model(k, S_W, S_H, S_HF, S_HS, S_HB, S_VF, S_VS, S_VB));
    if (se_s) se_cnt_s++;
    if (!vs_s) vs_run_s++;
    else if (vs_run_s > 0) begin
      vs_last_run_s = vs_run_s;
      vs_run_s = 0;
    end
  endtask

  // Assert reset between clock edges, confirm the outputs clear without an
  // edge, hold for two edges, then release on a falling edge.
  task automatic async_reset(input int offset);
    #(offset);
    reset = 1'b1;
    #1;
    check_reset_vals("async_rst");
    repeat (2) @(posedge clk25);
    #1;
    check_reset_vals("rst_hold");
    @(negedge clk25);
    reset = 1'b0;
    k = 0;
    se_cnt_s = 0;
    vs_run_s = 0;
    vs_last_run_s = 0;
  endtask

  typedef struct {
    int         k;
    logic       act;
    logic       hs;
    logic       vs;
    logic [9:0] x;
    logic [8:0] y;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #(40 * 100000);
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Standard-geometry line timing, hand-derived from the 640/16/96/48 line.
    tbl[0]  = '{1,    1'b1, 1'b1, 1'b1, 10'd0,   9'd0};
    tbl[1]  = '{2,    1'b1, 1'b1, 1'b1, 10'd1,   9'd0};
    tbl[2]  = '{640,  1'b1, 1'b1, 1'b1, 10'd639, 9'd0};
    tbl[3]  = '{641,  1'b0, 1'b1, 1'b1, 10'd0,   9'd0};
    tbl[4]  = '{656,  1'b0, 1'b1, 1'b1, 10'd0,   9'd0};
    tbl[5]  = '{657,  1'b0, 1'b0, 1'b1, 10'd0,   9'd0};
    tbl[6]  = '{752,  1'b0, 1'b0, 1'b1, 10'd0,   9'd0};
    tbl[7]  = '{753,  1'b0, 1'b1, 1'b1, 10'd0,   9'd0};
    tbl[8]  = '{800,  1'b0, 1'b1, 1'b1, 10'd0,   9'd0};
    tbl[9]  = '{801,  1'b1, 1'b1, 1'b1, 10'd0,   9'd1};
    tbl[10] = '{1440, 1'b1, 1'b1, 1'b1, 10'd639, 9'd1};
    tbl[11] = '{1601, 1'b1, 1'b1, 1'b1, 10'd0,   9'd2};

    reset = 1'b1;
    repeat (3) @(posedge clk25);
    #1;
    check_reset_vals("reset");
    @(negedge clk25);
    reset = 1'b0;
    k = 0;

    for (int i = 0; i < 12; i++) begin
      while (k < tbl[i].k) step();
      check("table", got_big(), {1'b0, tbl[i].act, tbl[i].hs, tbl[i].vs, tbl[i].x, tbl[i].y});
    end

    // Three complete small frames: one screenEnd each, vSync low for V_SYNC lines.
    while (k < 3 * S_FRAME) step();
    check_int("screenEnd_per_frame", se_cnt_s, 3);
    check_int("vsync_low_run", vs_last_run_s, S_VS * S_HT);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check_int("frameCount_3", int'(fc_s), 3);
`endif

    // Reset during the second vSync line at h = 22 of the small geometry.
    async_reset(5);
    while (k < (S_H + S_VF + 1) * S_HT + 22 + 1) step();
    check_int("in_vsync_before_rst", int'(vs_s), 0);
    async_reset(7);
    repeat (100) step();

    // Random run lengths with reset pulses landing at random points.
    for (int it = 0; it < 15; it++) begin
      int n;
      n = $urandom_range(1, 2500);
      repeat (n) step();
      async_reset($urandom_range(1, 15));
    end
    repeat (50) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates standard 640x480@60 Hz VGA raster timing from a 25 MHz pixel clock.
- Provides the current pixel coordinate, an active-video flag, negative-polarity H/V sync and a once-per-frame end-of-screen strobe.
- Sits between the system clock divider and the pixel colour pipeline (image RAM, palette, overlay logic) of the video controller.

Parameters:
- WIDTH, 640, visible pixels per line
- HEIGHT, 480, visible lines per frame
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- clk25  input  1  pixel clock, 25 MHz, rising edge
- reset  input  1  asynchronous, active-high reset
- screenEnd  output  1  one-cycle pulse at the start of vertical blanking
- active  output  1  high while the visible region is being drawn
- hSync  output  1  horizontal sync, active low
- vSync  output  1  vertical sync, active low
- x  output  10  column of current pixel (from left)
- y  output  9  row of current pixel (from top)

Behaviour:
- Internal counters: hCount 0..H_TOTAL-1, where H_TOTAL = WIDTH+H_FRONT+H_SYNC+H_BACK = 800. vCount 0..V_TOTAL-1, where V_TOTAL = HEIGHT+V_FRONT+V_SYNC+V_BACK = 525. Both are 10 bits wide.
- hCount increments every clk25 edge. At H_TOTAL-1 it wraps to 0 and vCount increments. vCount wraps from V_TOTAL-1 to 0 on the same edge that hCount wraps.
- All outputs are registered and computed from the pre-increment counter values on the same edge. Outputs therefore lag the counters by exactly one cycle.
- Decode rules for a counter pair (h,v):
  - active = (h < WIDTH) && (v < HEIGHT)
  - hSync = 0 iff WIDTH+H_FRONT <= h < WIDTH+H_FRONT+H_SYNC, i.e. 656..751
  - vSync = 0 iff HEIGHT+V_FRONT <= v < HEIGHT+V_FRONT+V_SYNC, i.e. 490..491, for the whole line including its blanking
  - x = h if h < WIDTH, else 0
  - y = v if v < HEIGHT, else 0 (no truncation artefacts for v >= 480)
  - screenEnd = 1 iff h == 0 && v == HEIGHT; exactly one cycle per frame
- Reset (asynchronous, any time, including mid-line or mid-sync):
  - hCount = 0, vCount = 0
  - active = 0, hSync = 1, vSync = 1, screenEnd = 0, x = 0, y = 0
- First rising edge after reset deassertion: outputs reflect (0,0), so active = 1, x = 0, y = 0. Counters advance to (1,0).
- Line period 800 cycles; frame period 420000 cycles. No other inputs and no handshake.

Optional Feature:
- Macro VGA_TIMING_FRAME_CNT_EN.
- When defined: adds output frameCount [15:0].
  - Reset value 0.
  - Increments by 1 (wrapping at 65535) on the same edge that screenEnd is registered high.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - default timing constants: WIDTH, HEIGHT, porch and sync widths
  - derived H_TOTAL / V_TOTAL
  - the counter width localparam (10)
- One natural sub-module: vga_axis_counter.
  - Parameterised modulo counter with enable, wrap-out flag and async reset.
  - Instantiated twice: horizontal, enabled always; vertical, enabled by the horizontal wrap.

Test Plan:
- Reset asserted → active = 0, hSync = 1, vSync = 1, screenEnd = 0, x = 0, y = 0. Release, one edge → active = 1, x = 0, y = 0. After 639 more edges x = 639; next edge active = 0, x = 0.
- Line timing → hSync falls exactly 656 cycles after the first x = 0 of a line and stays low for 96 cycles. Line repeats every 800 cycles; y increments by 1 each line.
- Frame timing → y = 479 on the last active line, then active stays 0 for 45 lines. vSync is low for exactly 1600 consecutive cycles (lines 490–491). Frame repeats every 420000 cycles.
- screenEnd → exactly one high cycle per 420000 cycles, coinciding with the first output cycle of line 480. With VGA_TIMING_FRAME_CNT_EN defined, frameCount reads 3 after three frames.
- Reset asserted mid-frame (during vSync low at line 491, h = 700) → all outputs immediately take their reset values without waiting for a clock edge. After release, timing restarts from (0,0).
